// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory
// handshakes, optional bus timeout and halt on EBREAK or illegal opcode.
module riscv_mc_ctrl #(
  parameter bit          HALT_ON_EBREAK  = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       inst_bit20,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic [2:0] mem2reg,
  output logic [1:0] pc_src_ctrl,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT    = 3'd5;

  localparam logic [3:0] C_ILL = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3,
                         C_JALR = 4'd4, C_BRANCH = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7,
                         C_OP_IMM = 4'd8, C_OP = 4'd9, C_MISC = 4'd10, C_SYSTEM = 4'd11;

  function automatic logic [3:0] classify(input logic [6:0] opc);
    logic [3:0] c;
    case (opc)
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b1100011: c = C_BRANCH;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b0010011: c = C_OP_IMM;
      7'b0110011: c = C_OP;
      7'b0001111: c = C_MISC;
      7'b1110011: c = C_SYSTEM;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             tmo_hit, exec_halt, exec_nop;

  // The counter holds the number of un-acked request cycles already spent.
  assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST);
  assign exec_halt = ((cls_q == C_SYSTEM) && inst_bit20 && HALT_ON_EBREAK) ||
                     ((cls_q == C_ILL) && TRAP_ON_ILLEGAL);
  assign exec_nop  = (cls_q == C_MISC) ||
                     (((cls_q == C_SYSTEM) || (cls_q == C_ILL)) && !exec_halt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILL;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        cls_d   = classify(opcode);
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if ((cls_q == C_LOAD) || (cls_q == C_STORE)) begin
          state_d = S_MEM;
        end else if ((cls_q == C_BRANCH) || exec_nop) begin
          state_d = S_FETCH;
        end else if (exec_halt) begin
          state_d = S_HALT;
          if (cls_q == C_ILL) illegal_d = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem2reg     = 3'b000;
    pc_src_ctrl = 2'b00;
    alu_op      = 2'b00;
    retire      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    state       = 3'd0;
    if (rst_n) begin
      state   = state_q;
      illegal = illegal_q;
      bus_err = bus_err_q;
      if (state_q inside {S_EXECUTE, S_MEM, S_WB}) begin
        case (cls_q)
          C_LUI:    begin alu_src = 1'b1; mem2reg = 3'b010; end
          C_AUIPC:  begin alu_src = 1'b1; mem2reg = 3'b100; end
          C_JAL:    mem2reg = 3'b011;
          C_JALR:   mem2reg = 3'b011;
          C_LOAD:   begin alu_src = 1'b1; mem2reg = 3'b001; end
          C_STORE:  alu_src = 1'b1;
          C_OP_IMM: begin alu_src = 1'b1; alu_op = 2'b10; end
          C_OP:     alu_op = 2'b10;
          C_BRANCH: alu_op = 2'b01;
          default:  ;
        endcase
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        S_EXECUTE: begin
          if (cls_q == C_BRANCH) begin
            pc_write    = 1'b1;
            retire      = 1'b1;
            pc_src_ctrl = branch_taken ? 2'b01 : 2'b00;
          end else if (exec_nop) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          if (dmem_ack && (cls_q == C_STORE)) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
          if (cls_q == C_JAL)  pc_src_ctrl = 2'b01;
          if (cls_q == C_JALR) pc_src_ctrl = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: one table of instructions with expected
// state sequences and control values, plus reset and halt corner sequences.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] OPC_OP    = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_LOAD  = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BR    = 7'b1100011, OPC_JALR  = 7'b1100111,
                         OPC_JAL   = 7'b1101111, OPC_LUI   = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_MISC  = 7'b0001111,
                         OPC_SYS   = 7'b1110011, OPC_BAD   = 7'b1111111,
                         OPC_ZERO  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       inst_bit20 = 1'b0, branch_taken = 1'b0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       sel = 1'b0;

  logic a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_reg_write, a_alu_src;
  logic a_retire, a_halted, a_illegal, a_bus_err;
  logic [2:0] a_mem2reg, a_state;
  logic [1:0] a_pc_src, a_alu_op;
  logic b_imem_req, b_dmem_req, b_dmem_we, b_ir_write, b_pc_write, b_reg_write, b_alu_src;
  logic b_retire, b_halted, b_illegal, b_bus_err;
  logic [2:0] b_mem2reg, b_state;
  logic [1:0] b_pc_src, b_alu_op;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.HALT_ON_EBREAK(1'b1), .TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .inst_bit20(inst_bit20),
    .branch_taken(branch_taken), .imem_req(a_imem_req), .imem_ack(imem_ack),
    .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_ack(dmem_ack),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
    .alu_src(a_alu_src), .mem2reg(a_mem2reg), .pc_src_ctrl(a_pc_src), .alu_op(a_alu_op),
    .retire(a_retire), .halted(a_halted), .illegal(a_illegal), .bus_err(a_bus_err),
    .state(a_state));

  riscv_mc_ctrl #(.HALT_ON_EBREAK(1'b0), .TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .inst_bit20(inst_bit20),
    .branch_taken(branch_taken), .imem_req(b_imem_req), .imem_ack(imem_ack),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_ack(dmem_ack),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
    .alu_src(b_alu_src), .mem2reg(b_mem2reg), .pc_src_ctrl(b_pc_src), .alu_op(b_alu_op),
    .retire(b_retire), .halted(b_halted), .illegal(b_illegal), .bus_err(b_bus_err),
    .state(b_state));

  logic [20:0] out_a, out_b, obs;
  assign out_a = {a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_reg_write,
                  a_alu_src, a_mem2reg, a_pc_src, a_alu_op, a_retire, a_halted, a_illegal,
                  a_bus_err, a_state};
  assign out_b = {b_imem_req, b_dmem_req, b_dmem_we, b_ir_write, b_pc_write, b_reg_write,
                  b_alu_src, b_mem2reg, b_pc_src, b_alu_op, b_retire, b_halted, b_illegal,
                  b_bus_err, b_state};
  assign obs = sel ? out_b : out_a;

  logic o_imem_req, o_dmem_req, o_dmem_we, o_pc_write, o_reg_write, o_retire, o_halted;
  logic [2:0] o_state;
  assign o_imem_req  = obs[20];
  assign o_dmem_req  = obs[19];
  assign o_dmem_we   = obs[18];
  assign o_pc_write  = obs[16];
  assign o_reg_write = obs[15];
  assign o_retire    = obs[6];
  assign o_halted    = obs[5];
  assign o_state     = obs[2:0];

  typedef struct {
    logic [6:0]  opc;
    logic        b20;
    logic        tkn;
    int          ilat;
    int          dlat;
    logic        sel;
    logic        rst;
    int          cyc;
    logic [31:0] seq;   // one nibble per cycle: state+1, oldest first
    logic [2:0]  m2r;
    logic [1:0]  pcs;
    logic        asrc;
    logic [1:0]  aop;
    int          rw;
    int          dreq;
    logic        we;
    int          ret;
    logic        halt;
    logic        ill;
    logic        berr;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int iw, dw, cyc, rw, dreq, ret, pw;
    logic [31:0] seq;
    logic we, done;
    logic [20:0] cap;
    v = vt[i];
    sel = v.sel;
    if (v.rst) do_reset();
    opcode = v.opc; inst_bit20 = v.b20; branch_taken = v.tkn;
    iw = 0; dw = 0; cyc = 0; rw = 0; dreq = 0; ret = 0; pw = 0;
    seq = '0; we = 1'b0; done = 1'b0; cap = '0;
    while (!done && cyc < 40) begin
      #1;
      imem_ack = o_imem_req && (iw == v.ilat);
      dmem_ack = o_dmem_req && (dw == v.dlat);
      #1;
      cyc++;
      seq = {seq[27:0], {1'b0, o_state} + 4'd1};
      if (o_imem_req) iw++;
      if (o_dmem_req) begin dw++; dreq++; we = o_dmem_we; end
      if (o_reg_write) rw++;
      if (o_pc_write) pw++;
      if (o_retire) ret++;
      if (o_retire || o_halted) begin done = 1'b1; cap = obs; end
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d cycles", i), cyc, v.cyc);
    chk($sformatf("v%0d state_seq", i), seq, v.seq);
    chk($sformatf("v%0d mem2reg", i), {29'd0, cap[13:11]}, {29'd0, v.m2r});
    chk($sformatf("v%0d pc_src", i), {30'd0, cap[10:9]}, {30'd0, v.pcs});
    chk($sformatf("v%0d alu_src", i), {31'd0, cap[14]}, {31'd0, v.asrc});
    chk($sformatf("v%0d alu_op", i), {30'd0, cap[8:7]}, {30'd0, v.aop});
    chk($sformatf("v%0d reg_write_cnt", i), rw, v.rw);
    chk($sformatf("v%0d pc_write_cnt", i), pw, v.ret);
    chk($sformatf("v%0d dmem_req_cnt", i), dreq, v.dreq);
    chk($sformatf("v%0d dmem_we", i), {31'd0, we}, {31'd0, v.we});
    chk($sformatf("v%0d retire", i), ret, v.ret);
    chk($sformatf("v%0d halted", i), {31'd0, cap[5]}, {31'd0, v.halt});
    chk($sformatf("v%0d illegal", i), {31'd0, cap[4]}, {31'd0, v.ill});
    chk($sformatf("v%0d bus_err", i), {31'd0, cap[3]}, {31'd0, v.berr});
    if (v.halt) begin
      imem_ack = 1'b1; dmem_ack = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk($sformatf("v%0d halt_hold", i),
          {25'd0, o_halted, o_state, o_imem_req, o_dmem_req, o_retire}, {25'd0, 1'b1, 3'd5, 3'b000});
      imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // opc, b20, tkn, ilat, dlat, sel, rst, cyc, seq, m2r, pcs, asrc, aop, rw, dreq, we, ret, halt, ill, berr
    vt[0]  = '{OPC_OP,    1'b0, 1'b0, 0, 0,  1'b0, 1'b1, 4, 32'h1235,     3'b000, 2'b00, 1'b0, 2'b10, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{OPC_OPIMM, 1'b0, 1'b0, 2, 0,  1'b0, 1'b0, 6, 32'h111235,   3'b000, 2'b00, 1'b1, 2'b10, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{OPC_LOAD,  1'b0, 1'b0, 0, 3,  1'b0, 1'b0, 8, 32'h12344445, 3'b001, 2'b00, 1'b1, 2'b00, 1, 4, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{OPC_STORE, 1'b0, 1'b0, 0, 1,  1'b0, 1'b0, 5, 32'h12344,    3'b000, 2'b00, 1'b1, 2'b00, 0, 2, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{OPC_BR,    1'b0, 1'b1, 0, 0,  1'b0, 1'b0, 3, 32'h123,      3'b000, 2'b01, 1'b0, 2'b01, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{OPC_BR,    1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 3, 32'h123,      3'b000, 2'b00, 1'b0, 2'b01, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{OPC_JALR,  1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 4, 32'h1235,     3'b011, 2'b10, 1'b0, 2'b00, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{OPC_JAL,   1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 4, 32'h1235,     3'b011, 2'b01, 1'b0, 2'b00, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{OPC_LUI,   1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 4, 32'h1235,     3'b010, 2'b00, 1'b1, 2'b00, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{OPC_AUIPC, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 4, 32'h1235,     3'b100, 2'b00, 1'b1, 2'b00, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{OPC_MISC,  1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 3, 32'h123,      3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{OPC_SYS,   1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 3, 32'h123,      3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{OPC_OP,    1'b0, 1'b0, 3, 0,  1'b0, 1'b0, 7, 32'h1111235,  3'b000, 2'b00, 1'b0, 2'b10, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[13] = '{OPC_SYS,   1'b1, 1'b0, 0, 0,  1'b0, 1'b0, 4, 32'h1236,     3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vt[14] = '{OPC_BAD,   1'b0, 1'b0, 0, 0,  1'b0, 1'b1, 4, 32'h1236,     3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    vt[15] = '{OPC_ZERO,  1'b0, 1'b0, 0, 0,  1'b0, 1'b1, 4, 32'h1236,     3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    vt[16] = '{OPC_OP,    1'b0, 1'b0, 99, 0, 1'b0, 1'b1, 5, 32'h11116,    3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vt[17] = '{OPC_LOAD,  1'b0, 1'b0, 0, 99, 1'b0, 1'b1, 8, 32'h12344446, 3'b000, 2'b00, 1'b0, 2'b00, 0, 4, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vt[18] = '{OPC_BAD,   1'b0, 1'b0, 0, 0,  1'b1, 1'b1, 3, 32'h123,      3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[19] = '{OPC_SYS,   1'b1, 1'b0, 0, 0,  1'b1, 1'b0, 3, 32'h123,      3'b000, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[20] = '{OPC_OP,    1'b0, 1'b0, 5, 0,  1'b1, 1'b0, 9, 32'h11111235, 3'b000, 2'b00, 1'b0, 2'b10, 1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};

    // Outputs forced low while in reset, even with acks asserted.
    opcode = OPC_OP; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_out_a", {11'd0, out_a}, 32'd0);
    chk("reset_out_b", {11'd0, out_b}, 32'd0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_cycle_req", {28'd0, a_imem_req, a_state}, {28'd0, 1'b1, 3'd0});
    chk("first_cycle_quiet", {24'd0, a_dmem_req, a_pc_write, a_reg_write, a_retire,
                              a_halted, a_illegal, a_bus_err, a_ir_write}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset asserted while a load waits in MEM.
    begin
      logic found;
      found = 1'b0;
      sel = 1'b0;
      do_reset();
      opcode = OPC_LOAD; inst_bit20 = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        imem_ack = a_imem_req;
        dmem_ack = 1'b0;
        #1;
        if (a_state == 3'd3) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("reached_mem", {31'd0, found}, 32'd1);
      chk("mem_req_before_rst", {30'd0, a_dmem_req, a_dmem_we}, {30'd0, 2'b10});
      rst_n = 1'b0;
      imem_ack = 1'b0;
      #1;
      chk("rst_mid_mem", {11'd0, out_a}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      #1;
      chk("after_rst_fetch", {27'd0, a_imem_req, a_dmem_req, a_state}, {27'd0, 2'b10, 3'd0});
      @(posedge clk);
      #1;
      chk("stray_dmem_ack", {29'd0, a_state}, {29'd0, 3'd0});
      dmem_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle opcode decoder with a state machine that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It handshakes with instruction and data memories of arbitrary latency, adds an optional bus timeout, and can halt on EBREAK or on an illegal opcode. It sits between the instruction register and the datapath muxes/enables, and keeps the existing `mem2reg`, `pc_src_ctrl` and `alu_op` encodings.

## Interface
Parameters:
- `HALT_ON_EBREAK`, 1: EBREAK (SYSTEM opcode with `inst_bit20`=1) enters HALT; when 0 it retires as a NOP.
- `TRAP_ON_ILLEGAL`, 1: an unknown opcode enters HALT with `illegal`=1; when 0 it retires as a NOP.
- `MEM_TIMEOUT`, 0: maximum wait cycles for an ack; 0 disables the timeout. Counter width is `$clog2(MEM_TIMEOUT+1)`, minimum 1.

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: instruction[6:0] from the IR; valid from DECODE onward.
- `inst_bit20` in 1: instruction[20]; separates ECALL (0) from EBREAK (1).
- `branch_taken` in 1: branch comparator result; sampled in EXECUTE.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch data valid this cycle.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`=1.
- `dmem_ack` in 1: data access complete this cycle.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: update the PC.
- `reg_write` out 1: register file write enable.
- `alu_src` out 1: 1 = immediate operand.
- `mem2reg` out 3: writeback source. 000 ALU, 001 mem, 010 imm, 011 PC+4, 100 PC+imm.
- `pc_src_ctrl` out 2: next PC. 00 PC+4, 01 PC+imm, 10 rs1+imm.
- `alu_op` out 2: 00 add, 01 branch compare, 10 funct decode.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: core stopped.
- `illegal` out 1: sticky; the halt was caused by an illegal opcode.
- `bus_err` out 1: sticky; the halt was caused by a timeout.
- `state` out 3: debug view of the state register.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT.
- In DECODE the opcode is latched into an internal class register: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM, ILL. Opcode 0 is ILL.
- `alu_src`, `mem2reg`, `pc_src_ctrl` and `alu_op` are driven from the class register only in EXECUTE, MEM and WB. They are 0 in all other states.
- Per-class control values:
  - LUI: `alu_src`=1, `mem2reg`=010.
  - AUIPC: `alu_src`=1, `mem2reg`=100.
  - JAL: `mem2reg`=011, WB `pc_src_ctrl`=01.
  - JALR: `mem2reg`=011, WB `pc_src_ctrl`=10.
  - LOAD: `alu_src`=1, `mem2reg`=001.
  - STORE: `alu_src`=1.
  - OP_IMM: `alu_src`=1, `alu_op`=10.
  - OP: `alu_op`=10.
  - BRANCH: `alu_op`=01.
- FETCH: `imem_req`=1 until `imem_ack`. In the ack cycle `ir_write`=1 and the next state is DECODE.
- DECODE: one cycle; the next state is always EXECUTE.
- EXECUTE:
  - LOAD or STORE: next state MEM.
  - BRANCH: `pc_write`=1, `pc_src_ctrl` = `branch_taken` ? 01 : 00, `retire`=1, next state FETCH.
  - MISC_MEM, ECALL, and ILL when `TRAP_ON_ILLEGAL`=0: `pc_write`=1 with 00, `retire`=1, next state FETCH.
  - EBREAK when `HALT_ON_EBREAK`=1: next state HALT.
  - ILL when `TRAP_ON_ILLEGAL`=1: next state HALT and `illegal` is set.
  - All other classes: next state WB.
- MEM: `dmem_req`=1 and `dmem_we`=(class==STORE) until `dmem_ack`.
  - STORE ack: `pc_write`=1 with 00, `retire`=1, next state FETCH.
  - LOAD ack: next state WB.
- WB: `reg_write`=1, `pc_write`=1, `retire`=1, next state FETCH.
- HALT: `halted`=1 and all other control outputs 0. The only exit is reset.
- Timeout, when `MEM_TIMEOUT`>0:
  - The counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When the count reaches `MEM_TIMEOUT` with no ack: next state HALT and `bus_err` is set.
  - An ack in the same cycle the count reaches the limit wins; no error.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.

## Timing
- Reset:
  - While `rst_n`=0, all outputs are forced to 0 combinationally.
  - At the edge, state becomes FETCH; the class register, timeout counter, `illegal` and `bus_err` clear.
  - The first cycle with `rst_n`=1 has `imem_req`=1.
- Reset asserted mid-transaction abandons it: `req` drops in the same cycle and the bench must not expect an ack to complete.
- Cycles per instruction, with ack in the first request cycle: OP/OP_IMM/LUI/AUIPC/JAL/JALR 4; LOAD 5; STORE 4; BRANCH/MISC_MEM/ECALL 3. Each extra wait cycle on a memory adds 1.
- Request signals are held constant from assertion until the ack cycle inclusive and drop the cycle after the ack.
- `retire`, `pc_write`, `reg_write` and `ir_write` are single-cycle pulses.
- `reg_write` and `pc_write` are never asserted outside the states listed above.

## Test plan
- OP (0110011) with `imem_ack` and `dmem_ack` tied to 1 → states 0,1,2,4 repeating. In WB: `reg_write`=1, `alu_op`=10, `mem2reg`=000, `pc_src_ctrl`=00. `retire` pulses every 4 cycles.
- LOAD (0000011) with `dmem_ack` delayed 3 cycles → `dmem_req`=1, `dmem_we`=0 held for 4 cycles. Then WB with `mem2reg`=001. Total 8 cycles.
- BRANCH with `branch_taken`=1, then again with 0 → EXECUTE `pc_src_ctrl`=01, then 00. `reg_write` stays 0. 3 cycles each.
- JALR (1100111) → WB `pc_src_ctrl`=10, `mem2reg`=011. EBREAK (1110011, `inst_bit20`=1) with `HALT_ON_EBREAK`=1 → `halted`=1 and `state`=5 until reset.
- Opcode 7'b1111111 with `TRAP_ON_ILLEGAL`=1 → `halted`=1, `illegal`=1. With `TRAP_ON_ILLEGAL`=0 → `retire` after 3 cycles and `pc_write` with 00.
- `MEM_TIMEOUT`=4, `imem_ack` held 0 → `bus_err`=1 and HALT after 4 wait cycles; an ack on the 4th cycle gives no error. `rst_n`=0 during MEM → all outputs 0 immediately, FETCH after release.
